imem_boot_loader: RTL and testbench

- Instruction-memory responder on the IFU fetch interface: takes `inst_mem_address` and returns `inst_mem_data` in the same cycle.
- Also contains the boot-loader that fills the memory from a byte stream (UART receiver side) over a valid/ready handshake.
- Holds the core in reset until the program image is fully loaded.
- Sits between the UART RX block, the instruction store and the IFU.

---
 rtl/imem_boot_loader.sv | 181 ++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Instruction store with a byte-stream boot loader; optional checksum stage under IMEM_BOOT_CHECKSUM_EN.
// Latency: fetch read is combinational; hold releases the cycle after the final accepted byte.
// Backpressure: ldr_ready is decoded from state, so bytes are accepted only while loading.
module imem_boot_loader #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 15
) (
    input  logic                 brq_clk,
    input  logic                 brq_rst,
    input  logic                 ldr_start,
    input  logic                 ldr_valid,
    input  logic [7:0]           ldr_byte,
    output logic                 ldr_ready,
    input  logic [AddrWidth-1:0] inst_mem_address,
    output logic [DataWidth-1:0] inst_mem_data,
    output logic                 core_rst_hold,
    output logic                 ldr_err
);

    localparam int Depth = 2 ** AddrWidth;

`ifdef IMEM_BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_CSUM = 3'd3,
        ST_ERR  = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2
    } state_t;
`endif

    state_t                state_q;
    logic [1:0]            byte_idx_q;
    logic [23:0]           asm_q;
    logic [31:0]           len_q;
    logic [31:0]           word_cnt_q;
    logic [AddrWidth-1:0]  waddr_q;
    logic                  hold_q;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [DataWidth-1:0]  acc_q;
    logic                  err_q;
`endif

    logic                  accept;
    logic                  last_byte;
    logic [DataWidth-1:0]  word_dat;
    logic [31:0]           word_cnt_nxt;
    logic                  mem_we;

    logic [DataWidth-1:0]  mem_q [Depth];

    always_comb begin
        ldr_ready = 1'b0;
        case (state_q)
            ST_LEN, ST_LOAD: ldr_ready = 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            ST_CSUM:         ldr_ready = 1'b1;
`endif
            default:         ldr_ready = 1'b0;
        endcase
    end

    assign accept       = ldr_valid & ldr_ready;
    assign last_byte    = accept & (byte_idx_q == 2'd3);
    assign word_dat     = {ldr_byte, asm_q};
    assign word_cnt_nxt = word_cnt_q + 32'd1;
    // Gated by reset so a reset landing on a word boundary cannot leak a write.
    assign mem_we       = brq_rst & (state_q == ST_LOAD) & last_byte;

    always_ff @(posedge brq_clk) begin
        if (!brq_rst) begin
            state_q    <= ST_LEN;
            byte_idx_q <= 2'd0;
            asm_q      <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            waddr_q    <= '0;
            hold_q     <= 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
            acc_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            if (accept) begin
                byte_idx_q <= byte_idx_q + 2'd1;
                case (byte_idx_q)
                    2'd0:    asm_q[7:0]   <= ldr_byte;
                    2'd1:    asm_q[15:8]  <= ldr_byte;
                    2'd2:    asm_q[23:16] <= ldr_byte;
                    default: asm_q        <= asm_q;
                endcase
            end
            case (state_q)
                ST_LEN: begin
                    if (last_byte) begin
                        len_q      <= word_dat;
                        word_cnt_q <= '0;
                        waddr_q    <= '0;
                        if (word_dat == '0) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
                            state_q <= ST_CSUM;
`else
                            state_q <= ST_RUN;
                            hold_q  <= 1'b0;
`endif
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (last_byte) begin
                        waddr_q    <= waddr_q + AddrWidth'(1);
                        word_cnt_q <= word_cnt_nxt;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        acc_q      <= acc_q ^ word_dat;
                        if (word_cnt_nxt == len_q) state_q <= ST_CSUM;
`else
                        if (word_cnt_nxt == len_q) begin
                            state_q <= ST_RUN;
                            hold_q  <= 1'b0;
                        end
`endif
                    end
                end
`ifdef IMEM_BOOT_CHECKSUM_EN
                ST_CSUM: begin
                    if (last_byte) begin
                        if (word_dat == acc_q) begin
                            state_q <= ST_RUN;
                            hold_q  <= 1'b0;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_RUN, ST_ERR: begin
`else
                ST_RUN: begin
`endif
                    if (ldr_start) begin
                        state_q    <= ST_LEN;
                        hold_q     <= 1'b1;
                        byte_idx_q <= 2'd0;
                        asm_q      <= '0;
                        len_q      <= '0;
                        word_cnt_q <= '0;
                        waddr_q    <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
                        acc_q      <= '0;
                        err_q      <= 1'b0;
`endif
                    end
                end
                default: state_q <= ST_LEN;
            endcase
        end
    end

    // Instruction store is deliberately left out of reset so a reload can be partial.
    always_ff @(posedge brq_clk) begin
        if (mem_we) mem_q[waddr_q] <= word_dat;
    end

    assign inst_mem_data = hold_q ? '0 : mem_q[inst_mem_address];
    assign core_rst_hold = hold_q;

`ifdef IMEM_BOOT_CHECKSUM_EN
    assign ldr_err = err_q;
`else
    assign ldr_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: scoreboarded image loads, gaps, reload, reset mid-load, checksum.
module tb_imem_boot_loader;

    logic        brq_clk;
    logic        brq_rst;
    logic        ldr_start;
    logic        ldr_valid;
    logic [7:0]  ldr_byte;
    logic        ldr_ready;
    logic [14:0] inst_mem_address;
    logic [31:0] inst_mem_data;
    logic        core_rst_hold;
    logic        ldr_err;

    imem_boot_loader #(.DataWidth(32), .AddrWidth(15)) dut (
        .brq_clk          (brq_clk),
        .brq_rst          (brq_rst),
        .ldr_start        (ldr_start),
        .ldr_valid        (ldr_valid),
        .ldr_byte         (ldr_byte),
        .ldr_ready        (ldr_ready),
        .inst_mem_address (inst_mem_address),
        .inst_mem_data    (inst_mem_data),
        .core_rst_hold    (core_rst_hold),
        .ldr_err          (ldr_err)
    );

    initial brq_clk = 1'b0;
    always #5 brq_clk = ~brq_clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb_q[$];
    logic [31:0] img_q[$];
    logic [31:0] shadow [int];

    task automatic set_addr(input int a);
        @(negedge brq_clk);
        inst_mem_address = a[14:0];
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge brq_clk);
        @(negedge brq_clk);
        ldr_valid = 1'b1;
        ldr_byte  = b;
        n = 0;
        while (ldr_ready !== 1'b1 && n < 100) begin
            @(negedge brq_clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: ldr_ready=%b required 1", ldr_ready);
        end
        @(posedge brq_clk);
        #1;
        ldr_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max, input bit is_last);
        int g;
        for (int i = 0; i < 4; i++) begin
            g = (gap_max > 0) ? int'($urandom_range(1, gap_max)) : 0;
            if (is_last && i == 3) begin
                checks++;
                if (core_rst_hold !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_before_last: core_rst_hold=%b required 1", core_rst_hold);
                end
            end
            send_byte(w[8*i +: 8], g);
        end
    endtask

    // Sends length, img_q words and (when enabled) a checksum; scoreboard drained on success.
    task automatic load_image(input string tag, input int gap_max, input bit good_csum);
        int          n;
        int          total;
        logic [31:0] acc;
        bit          expect_run;
        exp_t        e;
        n     = img_q.size();
        acc   = '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
        total      = n + 2;
        expect_run = good_csum;
`else
        total      = n + 1;
        expect_run = 1'b1;
`endif
        send_word(n, gap_max, total == 1);
        for (int i = 0; i < n; i++) begin
            acc = acc ^ img_q[i];
            e.addr = i;
            e.data = img_q[i];
            sb_q.push_back(e);
            shadow[i] = img_q[i];
            send_word(img_q[i], gap_max, (i + 2) == total);
        end
`ifdef IMEM_BOOT_CHECKSUM_EN
        send_word(good_csum ? acc : 32'h0000_0000, gap_max, 1'b1);
`endif
        checks++;
        if (core_rst_hold !== !expect_run) begin
            errors++;
            $display("FAIL %s_hold_after_last: core_rst_hold=%b required %b", tag, core_rst_hold, !expect_run);
        end
        checks++;
        if (ldr_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_after_load: ldr_ready=%b required 0", tag, ldr_ready);
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (expect_run) begin
                set_addr(e.addr);
                checks++;
                if (inst_mem_data !== e.data) begin
                    errors++;
                    $display("FAIL %s_word%0d: got %h required %h", tag, e.addr, inst_mem_data, e.data);
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge brq_clk);
        ldr_start = 1'b1;
        @(posedge brq_clk);
        #1;
        ldr_start = 1'b0;
    endtask

    task automatic test_reset();
        brq_rst = 1'b0;
        repeat (2) @(posedge brq_clk);
        @(negedge brq_clk);
        brq_rst = 1'b1;
        #1;
        checks++;
        if (core_rst_hold !== 1'b1) begin errors++; $display("FAIL reset_hold: got %b required 1", core_rst_hold); end
        checks++;
        if (ldr_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", ldr_err); end
        checks++;
        if (ldr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ldr_ready); end
        checks++;
        if (inst_mem_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h required 0", inst_mem_data); end
    endtask

    task automatic test_basic_load();
        img_q = {32'h0050_0093, 32'h0010_0113};
        load_image("basic", 0, 1'b1);
    endtask

    task automatic test_zero_length();
        pulse_start();
        img_q = {};
        load_image("zero", 0, 1'b1);
        for (int a = 0; a < 2; a++) begin
            set_addr(a);
            checks++;
            if (inst_mem_data !== shadow[a]) begin
                errors++;
                $display("FAIL zero_unchanged%0d: got %h required %h", a, inst_mem_data, shadow[a]);
            end
        end
    endtask

    task automatic test_gaps();
        pulse_start();
        img_q = {32'h0050_0093, 32'h0010_0113};
        load_image("gaps", 5, 1'b1);
        @(negedge brq_clk);
        ldr_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ldr_byte = 8'hA0 + 8'(i);
            @(negedge brq_clk);
        end
        ldr_valid = 1'b0;
        checks++;
        if (ldr_ready !== 1'b0 || core_rst_hold !== 1'b0) begin
            errors++;
            $display("FAIL run_drop_state: ready=%b hold=%b required 0 0", ldr_ready, core_rst_hold);
        end
        for (int a = 0; a < 2; a++) begin
            set_addr(a);
            checks++;
            if (inst_mem_data !== shadow[a]) begin
                errors++;
                $display("FAIL run_drop_word%0d: got %h required %h", a, inst_mem_data, shadow[a]);
            end
        end
    endtask

    task automatic test_reload();
        pulse_start();
        checks++;
        if (core_rst_hold !== 1'b1 || ldr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_start: hold=%b ready=%b required 1 1", core_rst_hold, ldr_ready);
        end
        img_q = {32'hDEAD_BEEF};
        load_image("reload", 0, 1'b1);
        set_addr(1);
        checks++;
        if (inst_mem_data !== 32'h0010_0113) begin
            errors++;
            $display("FAIL reload_word1_kept: got %h required 00100113", inst_mem_data);
        end
    endtask

    task automatic test_reset_midload();
        logic [31:0] w;
        pulse_start();
        send_word(32'd3, 0, 1'b0);
        w = 32'h1122_3344;
        send_word(w, 0, 1'b0);
        shadow[0] = w;
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge brq_clk);
        brq_rst = 1'b0;
        inst_mem_address = 15'd0;
        @(posedge brq_clk);
        #1;
        brq_rst = 1'b1;
        checks++;
        if (core_rst_hold !== 1'b1 || ldr_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state: hold=%b ready=%b required 1 1", core_rst_hold, ldr_ready);
        end
        checks++;
        if (inst_mem_data !== 32'h0) begin
            errors++;
            $display("FAIL midrst_data: got %h required 0", inst_mem_data);
        end
        img_q = {32'hCAFE_F00D};
        load_image("midrst", 0, 1'b1);
        set_addr(1);
        checks++;
        if (inst_mem_data !== shadow[1]) begin
            errors++;
            $display("FAIL midrst_word1_kept: got %h required %h", inst_mem_data, shadow[1]);
        end
    endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        img_q = {32'h0050_0093, 32'h0010_0113};
        load_image("csum_good", 0, 1'b1);
        checks++;
        if (ldr_err !== 1'b0) begin errors++; $display("FAIL csum_good_err: got %b required 0", ldr_err); end
        pulse_start();
        load_image("csum_bad", 0, 1'b0);
        checks++;
        if (ldr_err !== 1'b1) begin errors++; $display("FAIL csum_bad_err: got %b required 1", ldr_err); end
        repeat (3) @(posedge brq_clk);
        #1;
        checks++;
        if (core_rst_hold !== 1'b1) begin errors++; $display("FAIL csum_bad_hold: got %b required 1", core_rst_hold); end
        pulse_start();
        checks++;
        if (ldr_err !== 1'b0 || core_rst_hold !== 1'b1 || ldr_ready !== 1'b1) begin
            errors++;
            $display("FAIL csum_restart: err=%b hold=%b ready=%b required 0 1 1", ldr_err, core_rst_hold, ldr_ready);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        brq_rst          = 1'b0;
        ldr_start        = 1'b0;
        ldr_valid        = 1'b0;
        ldr_byte         = 8'h00;
        inst_mem_address = '0;
        test_reset();
        test_basic_load();
        test_zero_length();
        test_gaps();
        test_reload();
        test_reset_midload();
`ifdef IMEM_BOOT_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
